pio_loader: RTL and testbench

Byte-stream front end for the PIO block: receives framed configuration commands over a valid/ready byte interface, for example from a UART receiver, and replays each frame as a single-cycle `action`/`din`/`index`/`mindex` write on the PIO's host port. It takes over from the hard-wired program/config ROM sequencer, so programs and state-machine configuration can be loaded at run time. It sits directly upstream of `pio`.

---
 rtl/pio_pkg.sv | 30 +++
 rtl/pio_loader.sv | 200 ++++++++++++++++++++
 tb/tb_pio_loader.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pio_pkg.sv
// Shared definitions for the PIO loader: action codes, loader states, frame length.
// PIO_LOADER_CSUM_EN adds the trailing checksum byte to each frame.
package pio_pkg;

  localparam logic [3:0] ACT_NONE = 4'd0;
  localparam logic [3:0] ACT_PROG = 4'd1;
  localparam logic [3:0] ACT_WRAP = 4'd2;
  localparam logic [3:0] ACT_PINS = 4'd5;
  localparam logic [3:0] ACT_EN   = 4'd6;
  localparam logic [3:0] ACT_DIV  = 4'd7;
  localparam logic [3:0] ACT_SIDE = 4'd8;

  typedef enum logic [2:0] {
    S_HDR,
    S_IDX,
    S_D3,
    S_D2,
    S_D1,
    S_D0,
    S_CSUM,
    S_ISSUE
  } loader_state_e;

`ifdef PIO_LOADER_CSUM_EN
  localparam int FRAME_LEN = 7;
`else
  localparam int FRAME_LEN = 6;
`endif

endpackage

// File: rtl/pio_loader.sv
// Byte-stream loader that replays framed commands as single-cycle PIO host writes.
// Optional macro PIO_LOADER_CSUM_EN: expect a trailing XOR checksum byte per frame.
//
// state   | meaning
// S_HDR   | idle, waiting for header byte {action, mindex, 2'b00}
// S_IDX   | waiting for instruction index byte
// S_D3..0 | waiting for data bytes, most significant first
// S_CSUM  | waiting for checksum byte (checksum build only)
// S_ISSUE | write presented to the PIO for one cycle, input stalled
module pio_loader
  import pio_pkg::*;
#(
  parameter int TIMEOUT = 50000
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [3:0]  action,
  output logic [31:0] din,
  output logic [4:0]  index,
  output logic [1:0]  mindex,
  output logic        busy,
  output logic        err,
  output logic [15:0] frame_cnt
);

  localparam logic [31:0] TIMEOUT_C = 32'(TIMEOUT);

  loader_state_e state_q, state_d;
  logic [3:0]  stg_act_q, stg_act_d;
  logic [1:0]  stg_mindex_q, stg_mindex_d;
  logic [4:0]  stg_index_q, stg_index_d;
  logic [31:0] stg_din_q, stg_din_d;
  logic [31:0] gap_q, gap_d;
  logic [3:0]  action_q, action_d;
  logic [31:0] din_q, din_d;
  logic [4:0]  index_q, index_d;
  logic [1:0]  mindex_q, mindex_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
`ifdef PIO_LOADER_CSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic xfer;
  logic timeout_hit;
  logic issue;

  assign in_ready  = (state_q != S_ISSUE);
  assign busy      = (state_q != S_HDR);
  assign action    = action_q;
  assign din       = din_q;
  assign index     = index_q;
  assign mindex    = mindex_q;
  assign err       = err_q;
  assign frame_cnt = cnt_q;

  always_comb begin
    state_d      = state_q;
    stg_act_d    = stg_act_q;
    stg_mindex_d = stg_mindex_q;
    stg_index_d  = stg_index_q;
    stg_din_d    = stg_din_q;
    action_d     = ACT_NONE;
    din_d        = din_q;
    index_d      = index_q;
    mindex_d     = mindex_q;
    err_d        = 1'b0;
    cnt_d        = cnt_q;
`ifdef PIO_LOADER_CSUM_EN
    csum_d       = csum_q;
`endif
    issue        = 1'b0;
    xfer         = in_valid && in_ready;
    timeout_hit  = (TIMEOUT != 0) && (state_q != S_HDR) && (state_q != S_ISSUE)
                   && (gap_q >= TIMEOUT_C);
    gap_d        = (xfer || state_q == S_HDR) ? 32'd0 : gap_q + 32'd1;

    // A byte arriving in the timeout cycle is dropped together with the frame.
    if (timeout_hit) begin
      state_d      = S_HDR;
      err_d        = 1'b1;
      gap_d        = 32'd0;
      stg_act_d    = '0;
      stg_mindex_d = '0;
      stg_index_d  = '0;
      stg_din_d    = '0;
    end else begin
      case (state_q)
        S_HDR: if (xfer) begin
          stg_act_d    = in_data[7:4];
          stg_mindex_d = in_data[3:2];
`ifdef PIO_LOADER_CSUM_EN
          csum_d       = in_data;
`endif
          state_d      = S_IDX;
        end
        S_IDX: if (xfer) begin
          stg_index_d = in_data[4:0];
`ifdef PIO_LOADER_CSUM_EN
          csum_d      = csum_q ^ in_data;
`endif
          state_d     = S_D3;
        end
        S_D3: if (xfer) begin
          stg_din_d[31:24] = in_data;
`ifdef PIO_LOADER_CSUM_EN
          csum_d           = csum_q ^ in_data;
`endif
          state_d          = S_D2;
        end
        S_D2: if (xfer) begin
          stg_din_d[23:16] = in_data;
`ifdef PIO_LOADER_CSUM_EN
          csum_d           = csum_q ^ in_data;
`endif
          state_d          = S_D1;
        end
        S_D1: if (xfer) begin
          stg_din_d[15:8] = in_data;
`ifdef PIO_LOADER_CSUM_EN
          csum_d          = csum_q ^ in_data;
`endif
          state_d         = S_D0;
        end
        S_D0: if (xfer) begin
          stg_din_d[7:0] = in_data;
`ifdef PIO_LOADER_CSUM_EN
          csum_d         = csum_q ^ in_data;
          state_d        = S_CSUM;
`else
          state_d        = S_ISSUE;
          issue          = 1'b1;
`endif
        end
`ifdef PIO_LOADER_CSUM_EN
        S_CSUM: if (xfer) begin
          if (in_data == csum_q) begin
            state_d = S_ISSUE;
            issue   = 1'b1;
          end else begin
            state_d = S_HDR;
            err_d   = 1'b1;
          end
        end
`endif
        S_ISSUE: state_d = S_HDR;
        default: state_d = S_HDR;
      endcase
    end

    // Outputs load on the final transfer edge so they are valid throughout S_ISSUE.
    if (issue && stg_act_d != ACT_NONE) begin
      action_d = stg_act_d;
      din_d    = stg_din_d;
      index_d  = stg_index_d;
      mindex_d = stg_mindex_d;
      cnt_d    = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q      <= S_HDR;
      stg_act_q    <= '0;
      stg_mindex_q <= '0;
      stg_index_q  <= '0;
      stg_din_q    <= '0;
      gap_q        <= '0;
      action_q     <= '0;
      din_q        <= '0;
      index_q      <= '0;
      mindex_q     <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
`ifdef PIO_LOADER_CSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      stg_act_q    <= stg_act_d;
      stg_mindex_q <= stg_mindex_d;
      stg_index_q  <= stg_index_d;
      stg_din_q    <= stg_din_d;
      gap_q        <= gap_d;
      action_q     <= action_d;
      din_q        <= din_d;
      index_q      <= index_d;
      mindex_q     <= mindex_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
`ifdef PIO_LOADER_CSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_pio_loader.sv
// Directed bench for pio_loader: frame issue, back-to-back throughput, timeout, reset, null action.
// Honours PIO_LOADER_CSUM_EN by appending checksum bytes and running the checksum cases.
module tb_pio_loader;

  logic        clk;
  logic        n_reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  action;
  logic [31:0] din;
  logic [4:0]  index;
  logic [1:0]  mindex;
  logic        busy;
  logic        err;
  logic [15:0] frame_cnt;

  int n_chk;
  int n_fail;
  int err_pulses;

  pio_loader #(.TIMEOUT(8)) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .action    (action),
    .din       (din),
    .index     (index),
    .mindex    (mindex),
    .busy      (busy),
    .err       (err),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial err_pulses = 0;
  always @(negedge clk) if (err === 1'b1) err_pulses++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Returns 1 time unit after the final transfer edge, i.e. inside S_ISSUE.
  task automatic send_frame(input logic [7:0] h, input logic [7:0] i, input logic [7:0] d3,
                            input logic [7:0] d2, input logic [7:0] d1, input logic [7:0] d0);
    send_byte(h);
    send_byte(i);
    send_byte(d3);
    send_byte(d2);
    send_byte(d1);
    send_byte(d0);
`ifdef PIO_LOADER_CSUM_EN
    send_byte(h ^ i ^ d3 ^ d2 ^ d1 ^ d0);
`endif
    in_valid = 1'b0;
  endtask

  logic [7:0] bb[$];

  task automatic push_frame(input logic [7:0] h, input logic [7:0] i, input logic [7:0] d3,
                            input logic [7:0] d2, input logic [7:0] d1, input logic [7:0] d0);
    bb.push_back(h); bb.push_back(i); bb.push_back(d3);
    bb.push_back(d2); bb.push_back(d1); bb.push_back(d0);
`ifdef PIO_LOADER_CSUM_EN
    bb.push_back(h ^ i ^ d3 ^ d2 ^ d1 ^ d0);
`endif
  endtask

  initial begin
    int ptr, issues, c1, c2, e0, gap_exp;
    logic rdy;
    logic [3:0] a1, a2;
    logic [1:0] m2;
    logic [31:0] d1v, d2v;
    bit err_seen;

    n_chk = 0; n_fail = 0;
    n_reset = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_action", 32'(action), 32'd0);
    chk("rst_din", din, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    #11 n_reset = 1'b1;
    @(posedge clk); #1;

    // Program load
    send_frame(8'h10, 8'h03, 8'h00, 8'h00, 8'hE0, 8'h81);
    chk("prog_action", 32'(action), 32'd1);
    chk("prog_mindex", 32'(mindex), 32'd0);
    chk("prog_index", 32'(index), 32'd3);
    chk("prog_din", din, 32'h0000E081);
    chk("prog_cnt", 32'(frame_cnt), 32'd1);
    chk("prog_in_ready_issue", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("prog_action_clr", 32'(action), 32'd0);
    chk("prog_din_hold", din, 32'h0000E081);
    chk("prog_busy_idle", 32'(busy), 32'd0);

    // Back-to-back with valid held whenever data remains
    bb = {};
    push_frame(8'h60, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01);
    push_frame(8'h74, 8'h00, 8'h00, 8'h0F, 8'hFF, 8'hFF);
    ptr = 0; issues = 0; c1 = 0; c2 = 0;
    a1 = '0; a2 = '0; m2 = '0; d1v = '0; d2v = '0;
    for (int c = 0; c < 40; c++) begin
      in_valid = (ptr < bb.size());
      in_data  = in_valid ? bb[ptr] : 8'h00;
      rdy = in_ready;
      @(posedge clk);
      if (in_valid && rdy) ptr++;
      #1;
      if (action != 4'd0) begin
        if (issues == 0) begin c1 = c; a1 = action; d1v = din; end
        else begin c2 = c; a2 = action; m2 = mindex; d2v = din; end
        issues++;
      end
    end
    in_valid = 1'b0;
    chk("b2b_issues", 32'(issues), 32'd2);
`ifdef PIO_LOADER_CSUM_EN
    gap_exp = 8;
`else
    gap_exp = 7;
`endif
    chk("b2b_spacing", 32'(c2 - c1), 32'(gap_exp));
    chk("b2b_act1", 32'(a1), 32'd6);
    chk("b2b_din1", d1v, 32'h00000001);
    chk("b2b_act2", 32'(a2), 32'd7);
    chk("b2b_mindex2", 32'(m2), 32'd1);
    chk("b2b_din2", d2v, 32'h000FFFFF);
    chk("b2b_cnt", 32'(frame_cnt), 32'd3);

    // Timeout after HDR and IDX
    e0 = err_pulses;
    send_byte(8'h10);
    send_byte(8'h02);
    in_valid = 1'b0;
    chk("to_busy_mid", 32'(busy), 32'd1);
    err_seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (action != 4'd0) err_seen = 1'b1;
    end
    chk("to_err_pulses", 32'(err_pulses - e0), 32'd1);
    chk("to_busy_after", 32'(busy), 32'd0);
    chk("to_no_action", 32'(err_seen), 32'd0);
    chk("to_cnt", 32'(frame_cnt), 32'd3);
    send_frame(8'h80, 8'h07, 8'h12, 8'h34, 8'h56, 8'h78);
    chk("to_next_action", 32'(action), 32'd8);
    chk("to_next_index", 32'(index), 32'd7);
    chk("to_next_din", din, 32'h12345678);
    chk("to_next_cnt", 32'(frame_cnt), 32'd4);
    @(posedge clk); #1;

    // Gap of TIMEOUT-1 cycles must not drop the frame
    e0 = err_pulses;
    send_byte(8'h24);
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    send_byte(8'h1F);
    send_byte(8'hCA);
    send_byte(8'hFE);
    send_byte(8'hBA);
    send_byte(8'hBE);
`ifdef PIO_LOADER_CSUM_EN
    send_byte(8'h24 ^ 8'h1F ^ 8'hCA ^ 8'hFE ^ 8'hBA ^ 8'hBE);
`endif
    in_valid = 1'b0;
    chk("gap7_action", 32'(action), 32'd2);
    chk("gap7_mindex", 32'(mindex), 32'd1);
    chk("gap7_index", 32'(index), 32'd31);
    chk("gap7_din", din, 32'hCAFEBABE);
    chk("gap7_no_err", 32'(err_pulses - e0), 32'd0);
    @(posedge clk); #1;

    // Async reset mid-frame
    send_byte(8'h20);
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'hBB);
    #2 n_reset = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("ar_action", 32'(action), 32'd0);
    chk("ar_din", din, 32'd0);
    chk("ar_index", 32'(index), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_cnt", 32'(frame_cnt), 32'd0);
    chk("ar_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    n_reset = 1'b1;
    @(posedge clk); #1;
    send_frame(8'h50, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF);
    chk("ar_post_action", 32'(action), 32'd5);
    chk("ar_post_index", 32'(index), 32'd4);
    chk("ar_post_din", din, 32'hDEADBEEF);
    chk("ar_post_cnt", 32'(frame_cnt), 32'd1);
    @(posedge clk); #1;

    // Null action frame
    e0 = err_pulses;
    send_frame(8'h00, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04);
    chk("null_action", 32'(action), 32'd0);
    chk("null_busy_issue", 32'(busy), 32'd1);
    chk("null_din_hold", din, 32'hDEADBEEF);
    @(posedge clk); #1;
    chk("null_cnt", 32'(frame_cnt), 32'd1);
    chk("null_err", 32'(err_pulses - e0), 32'd0);
    chk("null_idle", 32'(busy), 32'd0);

`ifdef PIO_LOADER_CSUM_EN
    // Correct checksum 0x71 issues, 0x70 is dropped
    send_byte(8'h10); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'hE0); send_byte(8'h81);
    send_byte(8'h71);
    in_valid = 1'b0;
    chk("cs_good_action", 32'(action), 32'd1);
    chk("cs_good_din", din, 32'h0000E081);
    chk("cs_good_cnt", 32'(frame_cnt), 32'd2);
    @(posedge clk); #1;
    e0 = err_pulses;
    send_byte(8'h10); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'hE0); send_byte(8'h81);
    send_byte(8'h70);
    in_valid = 1'b0;
    chk("cs_bad_action", 32'(action), 32'd0);
    chk("cs_bad_err", 32'(err), 32'd1);
    chk("cs_bad_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("cs_bad_pulses", 32'(err_pulses - e0), 32'd1);
    chk("cs_bad_cnt", 32'(frame_cnt), 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
